// File: rtl/ram_arbiter.sv
// Two-port arbiter and sequencer for the single-port test RAM: port 0 fetches
// 64-bit words, port 1 loads/stores any width; one access issued per cycle.
module ram_arbiter #(
    parameter int unsigned NUM_BYTES   = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [63:0] addr0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [63:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic        we1,
    input  logic [63:0] addr1,
    input  logic [63:0] wdata1,
    input  logic [1:0]  width1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [63:0] rdata1,
    output logic        err1,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_data_in,
    output logic [1:0]  ram_width,
    input  logic [63:0] ram_data_out
);
    typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

    // Bit distance between the left-justified RAM lane and a right-justified value.
    function automatic logic [5:0] just_shift(input logic [1:0] w);
        case (w)
            2'd0:    return 6'd0;
            2'd1:    return 6'd32;
            2'd2:    return 6'd48;
            default: return 6'd56;
        endcase
    endfunction

    port_e       last_port;
    logic        conflict;
    logic        sel1;
    logic        grant;
    logic [63:0] addr;
    logic [63:0] offset;
    logic        borrow;
    logic [1:0]  width;
    logic [3:0]  nbytes;
    logic        in_range;

    logic        s1_valid;
    port_e       s1_port;
    logic        s1_read;
    logic        s1_err;
    logic [1:0]  s1_width;

    always_comb begin
        conflict = req0 && req1;
        sel1     = req1 && (!req0 || !ROUND_ROBIN || last_port == PORT0);
        gnt1     = !rst && sel1;
        gnt0     = !rst && req0 && !sel1;
        grant    = gnt0 || gnt1;
        addr     = sel1 ? addr1 : addr0;
        width    = sel1 ? width1 : 2'd0;
        nbytes   = 4'd8 >> width;
        // 65-bit subtract: the borrow flags addresses below the window without overflow.
        {borrow, offset} = {1'b0, addr} - {1'b0, BASE_ADDR};
        in_range = !borrow && (offset <= (64'(NUM_BYTES) - 64'(nbytes)));
        ram_cs      = grant && in_range;
        ram_we      = ram_cs && sel1 && we1;
        ram_addr    = ram_cs ? offset : '0;
        ram_width   = ram_cs ? width : '0;
        ram_data_in = ram_we ? (wdata1 << just_shift(width)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_port <= PORT0;
            s1_valid  <= 1'b0;
            s1_port   <= PORT0;
            s1_read   <= 1'b0;
            s1_err    <= 1'b0;
            s1_width  <= '0;
            rvalid0   <= 1'b0;
            rdata0    <= '0;
            err0      <= 1'b0;
            rvalid1   <= 1'b0;
            rdata1    <= '0;
            err1      <= 1'b0;
        end else begin
            if (conflict) last_port <= sel1 ? PORT1 : PORT0;
            s1_valid <= grant;
            s1_port  <= sel1 ? PORT1 : PORT0;
            s1_read  <= !(sel1 && we1);
            s1_err   <= !in_range;
            s1_width <= width;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            // In-range writes complete silently; reads and rejected ops respond.
            if (s1_valid && (s1_read || s1_err)) begin
                if (s1_port == PORT1) begin
                    rvalid1 <= 1'b1;
                    err1    <= s1_err;
                    rdata1  <= s1_err ? '0 : (ram_data_out >> just_shift(s1_width));
                end else begin
                    rvalid0 <= 1'b1;
                    err0    <= s1_err;
                    rdata0  <= s1_err ? '0 : ram_data_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, byte-array reference memory and a
// response scoreboard, plus directed and random scenarios.
module tb_ram_arbiter;
    localparam int unsigned NB   = 4096;
    localparam logic [63:0] BASE = 64'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [63:0] addr0 = '0, addr1 = '0, wdata1 = '0;
    logic [1:0]  width1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_cs, ram_we;
    logic [63:0] rdata0, rdata1, ram_addr, ram_data_in, ram_data_out;
    logic [1:0]  ram_width;

    ram_arbiter #(.NUM_BYTES(NB), .BASE_ADDR(BASE), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .width1(width1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_width(ram_width), .ram_data_out(ram_data_out)
    );

    logic        f_req0 = 1'b0, f_req1 = 1'b0, f_we1 = 1'b0;
    logic [63:0] f_addr0 = '0, f_addr1 = '0, f_wdata1 = '0, f_ram_data_out = '0;
    logic [1:0]  f_width1 = '0;
    logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_err0, f_err1, f_ram_cs, f_ram_we;
    logic [63:0] f_rdata0, f_rdata1, f_ram_addr, f_ram_data_in;
    logic [1:0]  f_ram_width;

    ram_arbiter #(.NUM_BYTES(NB), .BASE_ADDR(64'h0), .ROUND_ROBIN(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0(f_req0), .addr0(f_addr0), .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0), .err0(f_err0),
        .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1), .width1(f_width1),
        .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1), .err1(f_err1),
        .ram_cs(f_ram_cs), .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_data_in(f_ram_data_in),
        .ram_width(f_ram_width), .ram_data_out(f_ram_data_out)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    function automatic logic [7:0] init_byte(input int unsigned i);
        return 8'((i * 37 + 11) ^ (i >> 5));
    endfunction

    // Behavioural single-port RAM: big-endian bytes, data_out one cycle after a read.
    logic [7:0]  mem [NB];
    logic        loaded = 1'b0;
    logic [63:0] ram_q = '0;
    int unsigned ram_wr_count = 0;
    assign ram_data_out = ram_q;

    function automatic logic [63:0] ram_word(input logic [63:0] a);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < 8; i++)
            v = {v[55:0], ((a + 64'(i)) < 64'(NB)) ? mem[int'(a) + int'(i)] : 8'h00};
        return v;
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int unsigned i = 0; i < NB; i++) mem[i] <= init_byte(i);
            loaded <= 1'b1;
        end else if (ram_cs) begin
            if (ram_we) begin
                for (int unsigned i = 0; i < (8 >> ram_width); i++)
                    if ((ram_addr + 64'(i)) < 64'(NB))
                        mem[int'(ram_addr) + int'(i)] <= ram_data_in[63 - 8*i -: 8];
                ram_wr_count <= ram_wr_count + 1;
            end else begin
                ram_q <= ram_word(ram_addr);
            end
        end
    end

    // Reference model: expected memory contents and expected responses.
    logic [7:0] ref_mem [NB];
    typedef struct {
        int unsigned due;
        bit          port;
        logic [63:0] data;
        bit          err;
    } resp_t;
    resp_t       exp_q[$];
    int unsigned cyc = 0;
    bit          last1 = 1'b0;

    function automatic logic [63:0] ref_read(input int unsigned off, input int unsigned nb);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < nb; i++) v = (v << 8) | 64'(ref_mem[off + i]);
        return v;
    endfunction

    initial begin
        bit          ev[2];
        logic [63:0] ed[2];
        bit          ee[2];
        bit          w0, w1, ok, wr;
        logic [63:0] a, data;
        int unsigned nb, off;
        for (int unsigned i = 0; i < NB; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            cyc++;
            ev = '{1'b0, 1'b0};
            ed = '{64'h0, 64'h0};
            ee = '{1'b0, 1'b0};
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].due == cyc) begin
                    ev[exp_q[i].port] = 1'b1;
                    ed[exp_q[i].port] = exp_q[i].data;
                    ee[exp_q[i].port] = exp_q[i].err;
                    exp_q.delete(i);
                end
            end
            total++;
            if (rvalid0 !== ev[0]) begin
                bad++;
                $display("FAIL sb_rvalid0 cyc=%0d got=%b want=%b", cyc, rvalid0, ev[0]);
            end
            total++;
            if (rvalid1 !== ev[1]) begin
                bad++;
                $display("FAIL sb_rvalid1 cyc=%0d got=%b want=%b", cyc, rvalid1, ev[1]);
            end
            if (ev[0]) begin
                total++;
                if (rdata0 !== ed[0] || err0 !== ee[0]) begin
                    bad++;
                    $display("FAIL sb_resp0 cyc=%0d got=%h/%b want=%h/%b", cyc, rdata0, err0, ed[0], ee[0]);
                end
            end
            if (ev[1]) begin
                total++;
                if (rdata1 !== ed[1] || err1 !== ee[1]) begin
                    bad++;
                    $display("FAIL sb_resp1 cyc=%0d got=%h/%b want=%h/%b", cyc, rdata1, err1, ed[1], ee[1]);
                end
            end

            if (rst) begin
                exp_q.delete();
                last1 = 1'b0;
                total++;
                if ({gnt0, gnt1, ram_cs, ram_we} !== 4'b0000) begin
                    bad++;
                    $display("FAIL sb_reset_quiet cyc=%0d got=%b want=0000", cyc, {gnt0, gnt1, ram_cs, ram_we});
                end
            end else begin
                w1 = req1 && (!req0 || !last1);
                w0 = req0 && !w1;
                total++;
                if ({gnt0, gnt1} !== {w0, w1}) begin
                    bad++;
                    $display("FAIL sb_grant cyc=%0d got=%b%b want=%b%b", cyc, gnt0, gnt1, w0, w1);
                end
                if (w0 || w1) begin
                    a  = w1 ? addr1 : addr0;
                    nb = w1 ? (8 >> width1) : 8;
                    wr = w1 && we1;
                    ok = (a >= BASE) && (a + 64'(nb) <= BASE + 64'(NB));
                    total++;
                    if ({ram_cs, ram_we} !== {ok, ok && wr}) begin
                        bad++;
                        $display("FAIL sb_ram_ctl cyc=%0d got=%b%b want=%b%b", cyc, ram_cs, ram_we, ok, ok && wr);
                    end
                    data = '0;
                    if (ok) begin
                        off = int'(a - BASE);
                        total++;
                        if (ram_addr !== a - BASE) begin
                            bad++;
                            $display("FAIL sb_ram_addr cyc=%0d got=%h want=%h", cyc, ram_addr, a - BASE);
                        end
                        if (wr) begin
                            for (int unsigned i = 0; i < nb; i++)
                                ref_mem[off + i] = 8'(wdata1 >> (8 * (nb - 1 - i)));
                        end else begin
                            data = ref_read(off, nb);
                        end
                    end
                    if (!ok || !wr) exp_q.push_back('{cyc + 2, w1, data, !ok});
                end else begin
                    total++;
                    if ({ram_cs, ram_we} !== 2'b00) begin
                        bad++;
                        $display("FAIL sb_idle_ram cyc=%0d got=%b%b want=00", cyc, ram_cs, ram_we);
                    end
                end
                if (req0 && req1) last1 = w1;
            end
        end
    end

    // Issues one request, waits (bounded) for its grant and any response.
    task automatic do_op(input bit p, input bit we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [1:0] w, output logic [63:0] rd, output logic er,
                         output bit got, output int lat, output logic cs_g);
        int unsigned n;
        @(posedge clk); #1;
        if (p) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; width1 = w;
        end else begin
            req0 = 1'b1; addr0 = a;
        end
        n = 0;
        cs_g = 1'b0;
        forever begin
            @(negedge clk);
            if ((p ? gnt1 : gnt0) === 1'b1) begin
                cs_g = ram_cs;
                break;
            end
            n++;
            if (n > 20) begin
                total++;
                bad++;
                $display("FAIL grant_timeout port=%0d got=none want=gnt", p);
                break;
            end
        end
        @(posedge clk); #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
        got = 1'b0; rd = '0; er = 1'b0; lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ((p ? rvalid1 : rvalid0) === 1'b1) begin
                got = 1'b1; lat = i + 1;
                rd = p ? rdata1 : rdata0;
                er = p ? err1 : err0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_cs, ram_we} !== 8'h00 ||
            rdata0 !== '0 || rdata1 !== '0 || ram_addr !== '0 || ram_data_in !== '0 || ram_width !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b rd0=%h rd1=%h want=all zero",
                     {gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_cs, ram_we}, rdata0, rdata1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_conflict;
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = BASE + 64'h40;
        req1 = 1'b1; we1 = 1'b0; addr1 = BASE + 64'h80; width1 = 2'd0;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin bad++; $display("FAIL conflict_c1 got=%b%b want=01", gnt0, gnt1); end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL conflict_c2 got=%b%b want=10", gnt0, gnt1); end
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        total++;
        if ({rvalid0, rvalid1} !== 2'b01) begin bad++; $display("FAIL conflict_c3 got=%b%b want=01", rvalid0, rvalid1); end
        @(negedge clk);
        total++;
        if ({rvalid0, rvalid1} !== 2'b10) begin bad++; $display("FAIL conflict_c4 got=%b%b want=10", rvalid0, rvalid1); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed_priority;
        @(posedge clk); #1;
        f_req0 = 1'b1; f_addr0 = 64'h0;
        f_req1 = 1'b1; f_we1 = 1'b0; f_addr1 = 64'h8; f_width1 = 2'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({f_gnt0, f_gnt1} !== 2'b01) begin
                bad++;
                $display("FAIL fixed_prio k=%0d got=%b%b want=01", k, f_gnt0, f_gnt1);
            end
        end
        @(posedge clk); #1;
        f_req0 = 1'b0; f_req1 = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [63:0] off;
        logic [63:0] wd;
        logic [1:0]  w;
        logic [63:0] exp;
    } dop_t;

    task automatic test_data;
        dop_t        tbl[$];
        logic [63:0] rd;
        logic        er, cs_g;
        bit          got;
        int          lat;
        tbl = '{
            '{1'b1, 64'h100, 64'h0123456789ABCDEF, 2'd0, 64'h0},
            '{1'b1, 64'h108, 64'hFEEDFACE12345678, 2'd0, 64'h0},
            '{1'b0, 64'h101, 64'h0, 2'd3, 64'h23},
            '{1'b0, 64'h106, 64'h0, 2'd2, 64'hCDEF},
            '{1'b0, 64'h100, 64'h0, 2'd0, 64'h0123456789ABCDEF},
            '{1'b1, 64'h102, 64'h000000000000BEEF, 2'd2, 64'h0},
            '{1'b0, 64'h100, 64'h0, 2'd0, 64'h0123BEEF89ABCDEF},
            '{1'b0, 64'h104, 64'h0, 2'd0, 64'h89ABCDEFFEEDFACE},
            '{1'b0, 64'h10C, 64'h0, 2'd1, 64'h12345678}
        };
        foreach (tbl[i]) begin
            do_op(1'b1, tbl[i].we, BASE + tbl[i].off, tbl[i].wd, tbl[i].w, rd, er, got, lat, cs_g);
            total++;
            if (tbl[i].we) begin
                if (got || !cs_g) begin
                    bad++;
                    $display("FAIL data_write[%0d] got rvalid=%b cs=%b want rvalid=0 cs=1", i, got, cs_g);
                end
            end else if (!got || lat != 2 || er || rd !== tbl[i].exp) begin
                bad++;
                $display("FAIL data_read[%0d] got=%h err=%b lat=%0d want=%h err=0 lat=2", i, rd, er, lat, tbl[i].exp);
            end
        end
    endtask

    typedef struct {
        bit          p;
        bit          we;
        logic [63:0] a;
        logic [1:0]  w;
        bit          err;
    } rop_t;

    task automatic test_range;
        rop_t        tbl[$];
        logic [63:0] rd;
        logic        er, cs_g;
        bit          got;
        int          lat;
        int unsigned wr_before;
        tbl = '{
            '{1'b1, 1'b0, 64'h1FF8, 2'd0, 1'b0},
            '{1'b1, 1'b0, 64'h1FF9, 2'd0, 1'b1},
            '{1'b1, 1'b0, 64'h0FFF, 2'd3, 1'b1},
            '{1'b1, 1'b1, 64'h2000, 2'd0, 1'b1},
            '{1'b1, 1'b1, 64'h1FFE, 2'd1, 1'b1},
            '{1'b0, 1'b0, 64'h1FF9, 2'd0, 1'b1},
            '{1'b1, 1'b0, 64'h1FFF, 2'd3, 1'b0},
            '{1'b1, 1'b0, 64'h1FF8, 2'd0, 1'b0}
        };
        wr_before = ram_wr_count;
        foreach (tbl[i]) begin
            do_op(tbl[i].p, tbl[i].we, tbl[i].a, 64'hA5A5_5A5A_C3C3_3C3C, tbl[i].w, rd, er, got, lat, cs_g);
            total++;
            if (!got || lat != 2 || er !== tbl[i].err || cs_g !== !tbl[i].err ||
                rd !== (tbl[i].err ? 64'h0 : ref_read(int'(tbl[i].a - BASE), 8 >> tbl[i].w))) begin
                bad++;
                $display("FAIL range[%0d] got rv=%b lat=%0d err=%b cs=%b rd=%h want rv=1 lat=2 err=%b cs=%b",
                         i, got, lat, er, cs_g, rd, tbl[i].err, !tbl[i].err);
            end
        end
        total++;
        if (ram_wr_count != wr_before) begin
            bad++;
            $display("FAIL range_no_write got=%0d want=%0d", ram_wr_count, wr_before);
        end
    endtask

    task automatic test_stream;
        logic [63:0] exp;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            if (k < 16) begin
                req0 = 1'b1; addr0 = BASE + 64'(8 * k);
            end else begin
                req0 = 1'b0;
            end
            @(negedge clk);
            if (k < 16) begin
                total++;
                if (gnt0 !== 1'b1) begin bad++; $display("FAIL stream_gnt k=%0d got=%b want=1", k, gnt0); end
            end
            if (k >= 2) begin
                exp = ref_read(8 * (k - 2), 8);
                total++;
                if (rvalid0 !== 1'b1 || rdata0 !== exp) begin
                    bad++;
                    $display("FAIL stream_data k=%0d got=%b/%h want=1/%h", k, rvalid0, rdata0, exp);
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return BASE - 64'($urandom_range(1, 8));
            1:       return BASE + 64'(NB - 12 + $urandom_range(0, 16));
            default: return BASE + 64'($urandom_range(0, NB - 1));
        endcase
    endfunction

    task automatic test_random;
        bit pend0 = 1'b0, pend1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!pend0) begin
                req0 = 1'b0;
                if ($urandom_range(0, 2) != 0) begin req0 = 1'b1; addr0 = rand_addr(); pend0 = 1'b1; end
            end
            if (!pend1) begin
                req1 = 1'b0;
                if ($urandom_range(0, 2) != 0) begin
                    req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); width1 = 2'($urandom_range(0, 3));
                    addr1 = rand_addr(); wdata1 = {$urandom, $urandom}; pend1 = 1'b1;
                end
            end
            @(negedge clk);
            if (gnt0 === 1'b1) pend0 = 1'b0;
            if (gnt1 === 1'b1) pend1 = 1'b0;
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = BASE + 64'h200; width1 = 2'd0;
        @(negedge clk);
        total++;
        if (gnt1 !== 1'b1) begin bad++; $display("FAIL midflight_gnt got=%b want=1", gnt1); end
        @(posedge clk); #1;
        req1 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_cs, ram_we} !== 8'h00 ||
            rdata0 !== '0 || rdata1 !== '0) begin
            bad++;
            $display("FAIL midflight_outputs got=%b rd0=%h rd1=%h want=all zero",
                     {gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_cs, ram_we}, rdata0, rdata1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({rvalid0, rvalid1} !== 2'b00) begin
                bad++;
                $display("FAIL midflight_quiet k=%0d got=%b%b want=00", k, rvalid0, rvalid1);
            end
        end
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = BASE;
        req1 = 1'b1; we1 = 1'b0; addr1 = BASE + 64'h8; width1 = 2'd0;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin bad++; $display("FAIL midflight_conflict got=%b%b want=01", gnt0, gnt1); end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        req0 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_data();
        test_range();
        test_stream();
        test_fixed_priority();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port synchronous test RAM.
- Port 0 is instruction fetch (read-only, 64-bit). Port 1 is data load/store (read/write, any width).
- Issues one RAM access per cycle, pipelined, with round-robin or fixed priority.
- Range-checks addresses and rebases them into the RAM. Justifies write data and zero-extends read data, so requesters see right-justified values.

Parameters:
- NUM_BYTES, 4096: RAM size in bytes; must match the RAM instance; multiple of 8.
- BASE_ADDR, 64'h0: first byte address mapped to the RAM; 8-byte aligned.
- ROUND_ROBIN, 1: 1 = alternate on conflict; 0 = port 1 always wins.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 read request; hold with addr0 stable until gnt0.
- addr0  in  64  port 0 byte address.
- gnt0  out  1  one-cycle pulse: port 0 request accepted this cycle.
- rvalid0  out  1  one-cycle pulse: rdata0/err0 valid.
- rdata0  out  64  port 0 read data.
- err0  out  1  qualifies rvalid0: access out of range, rdata0 = 0.
- req1  in  1  port 1 request; hold with we1/addr1/wdata1/width1 stable until gnt1.
- we1  in  1  1 = write, 0 = read.
- addr1  in  64  port 1 byte address.
- wdata1  in  64  right-justified write data.
- width1  in  2  0 = 64b, 1 = 32b, 2 = 16b, 3 = 8b.
- gnt1  out  1  one-cycle pulse: port 1 request accepted.
- rvalid1  out  1  one-cycle pulse: read completed, or write completed with err1=1.
- rdata1  out  64  zero-extended, right-justified read data.
- err1  out  1  qualifies rvalid1: out of range.
- ram_cs, ram_we  out  1 each  to RAM cs/we.
- ram_addr  out  64  addr − BASE_ADDR.
- ram_data_in  out  64  left-justified write data.
- ram_width  out  2  to RAM write_width.
- ram_data_out  in  64  from RAM data_out; valid the cycle after an issue.

Behaviour:
- Reset: all outputs 0, pipeline valid bits cleared, RR pointer = "port 0 last", so port 1 wins the first conflict.
- Grant, combinational in the request cycle N:
  - One requester: it is granted.
  - Both requesting: ROUND_ROBIN=1 grants the port not granted last; ROUND_ROBIN=0 grants port 1.
  - Pointer updates only on a conflicted grant.
- Range check, nbytes = 8 >> width:
  - In range iff BASE_ADDR <= addr and addr − BASE_ADDR + nbytes <= NUM_BYTES, computed without 64-bit overflow.
  - Port 0 always uses nbytes = 8.
- In-range grant: in cycle N drive ram_cs=1, ram_addr, ram_width, ram_we=we.
  - Write data: ram_data_in = wdata1 << (64 − 8·nbytes).
- Out-of-range grant: ram_cs=0 and ram_we=0; the op still enters the pipeline flagged err.
- No grant: ram_cs=0, ram_we=0.
- Pipeline: stage 1 records {valid, port, read, err, width} at cycle N.
  - Stage 2 registers at the end of N+1: rdata = ram_data_out >> (64 − 8·nbytes), or 0 if err.
  - rvalidX pulses in cycle N+2.
- Writes: in-range writes produce no rvalid; out-of-range writes pulse rvalid1 with err1=1 at N+2.
- Throughput: one grant per cycle; a new issue is legal in the cycle prior data returns. No stall path, since responses are always accepted.
- Only the granted port's rvalid/rdata/err change; rdataX holds between pulses.
- Reset mid-flight: pending reads are discarded and no rvalid follows reset. Writes issued in the reset cycle are suppressed (ram_cs=0 while rst).
- A req dropped before its gnt is a protocol error and is not checked.

Test Plan:
- Reset, then req0 and req1 (both reads, in range) asserted together at cycle 1:
  - gnt1 at cycle 1, gnt0 at cycle 2.
  - rvalid1 at cycle 3, rvalid0 at cycle 4.
  - With ROUND_ROBIN=0 and both held, gnt1 every cycle and gnt0 never.
- Port 1 writes 64b 0x0123456789ABCDEF at 0x100, then performs these reads:
  - 8b read at 0x101 → rdata1=0x23.
  - 16b read at 0x106 → 0xCDEF.
  - 64b read at 0x100 → original value.
- 16b write of 0x000000000000BEEF at 0x102, then 64b read at 0x100 → 0x0123BEEF89ABCDEF.
  - The 64b read at unaligned 0x104 → 0x89ABCDEF00000000 plus the next word's upper 4 bytes.
- NUM_BYTES=4096, BASE_ADDR=0x1000:
  - 64b read at 0x1FF8 → ok.
  - 64b read at 0x1FF9, 8b read at 0x0FFF, and write at 0x2000 → ram_cs=0, rvalid1 with err1=1 at N+2, no RAM contents changed.
- Port 0 held requesting, addresses 0x0, 0x8, 0x10… → gnt0 every cycle, rvalid0 every cycle from cycle 3, data in order.
- Assert rst in the cycle after a read grant → no rvalid after reset, all outputs 0, first post-reset conflict granted to port 1.
